// File: rtl/bus_protocol_monitor.sv
// Passive checker for a dValid/dAck handshake bus with sticky error flags and per-transfer reporting.
// Optional statistics counters (xfer_count, err_count) are built when BUS_MON_STATS_EN is defined.
module bus_protocol_monitor #(
    parameter int DATA_W    = 8,
    parameter int MIN_VALID = 2,
    parameter int MAX_VALID = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dValid,
    input  logic              dAck,
    input  logic [DATA_W-1:0] data,
    input  logic              clr_err,
    output logic              busy,
    output logic [6:0]        err_flags,
    output logic              err_pulse,
    output logic              xfer_done,
    output logic [7:0]        xfer_len,
    output logic [DATA_W-1:0] xfer_data
`ifdef BUS_MON_STATS_EN
    ,
    output logic [CNT_W-1:0]  xfer_count,
    output logic [CNT_W-1:0]  err_count
`endif
);

    localparam int E_SHORT = 0;
    localparam int E_LONG  = 1;
    localparam int E_EARLY = 2;
    localparam int E_NOACK = 3;
    localparam int E_NODROP = 4;
    localparam int E_DATA  = 5;
    localparam int E_SPUR  = 6;

    localparam logic [7:0] MIN_LEN      = 8'(MIN_VALID);
    localparam logic [8:0] LONG_TRIGGER = 9'(MAX_VALID + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ACKED  = 2'd2
    } state_t;

    if (MIN_VALID < 1 || MIN_VALID > MAX_VALID || MAX_VALID > 255 || CNT_W < 1) begin : g_bad_params
        $error("bus_protocol_monitor: illegal parameter combination");
    end

    function automatic logic [7:0] len_sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t              state_q, state_d;
    logic [7:0]          len_q, len_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic                err_seen_q, err_seen_d;
    logic                long_seen_q, long_seen_d;
    logic                nodrop_seen_q, nodrop_seen_d;
    logic                busy_q;
    logic [6:0]          err_flags_q, err_flags_d;
    logic                err_pulse_q;
    logic                xfer_done_q, xfer_done_d;
    logic [7:0]          xfer_len_q, xfer_len_d;
    logic [DATA_W-1:0]   xfer_data_q, xfer_data_d;
    logic [6:0]          err_now_s;
    logic [7:0]          len_inc_s;
    logic                start_s;

    // Next-state, error detection and completion reporting for the current bus cycle
    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        hold_d        = hold_q;
        long_seen_d   = long_seen_q;
        nodrop_seen_d = nodrop_seen_q;
        xfer_done_d   = 1'b0;
        xfer_len_d    = xfer_len_q;
        xfer_data_d   = xfer_data_q;
        err_now_s     = 7'b0;
        start_s       = 1'b0;
        len_inc_s     = len_sat_inc(len_q);

        case (state_q)
            ST_IDLE: begin
                if (dValid) begin
                    start_s       = 1'b1;
                    state_d       = ST_ACTIVE;
                    len_d         = 8'd1;
                    hold_d        = data;
                    long_seen_d   = 1'b0;
                    nodrop_seen_d = 1'b0;
                    if (dAck) begin
                        if (8'd1 < MIN_LEN) begin
                            err_now_s[E_EARLY] = 1'b1;
                        end else begin
                            err_now_s[E_EARLY] = 1'b0;
                        end
                        state_d = ST_ACKED;
                    end else begin
                        state_d = ST_ACTIVE;
                    end
                end else if (dAck) begin
                    err_now_s[E_SPUR] = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (dValid) begin
                    len_d = len_inc_s;
                    if (data != hold_q) begin
                        err_now_s[E_DATA] = 1'b1;
                    end else begin
                        err_now_s[E_DATA] = 1'b0;
                    end
                    if (({1'b0, len_inc_s} == LONG_TRIGGER) && !long_seen_q) begin
                        err_now_s[E_LONG] = 1'b1;
                        long_seen_d       = 1'b1;
                    end else begin
                        err_now_s[E_LONG] = 1'b0;
                    end
                    if (dAck) begin
                        if (len_inc_s < MIN_LEN) begin
                            err_now_s[E_EARLY] = 1'b1;
                        end else begin
                            err_now_s[E_EARLY] = 1'b0;
                        end
                        state_d = ST_ACKED;
                    end else begin
                        state_d = ST_ACTIVE;
                    end
                end else begin
                    err_now_s[E_NOACK] = 1'b1;
                    if (len_q < MIN_LEN) begin
                        err_now_s[E_SHORT] = 1'b1;
                    end else begin
                        err_now_s[E_SHORT] = 1'b0;
                    end
                    state_d = ST_IDLE;
                end
            end
            ST_ACKED: begin
                if (dValid) begin
                    // A master that keeps dValid up after the ack is reported only once per transfer
                    len_d = len_inc_s;
                    if (!nodrop_seen_q) begin
                        err_now_s[E_NODROP] = 1'b1;
                        nodrop_seen_d       = 1'b1;
                    end else begin
                        err_now_s[E_NODROP] = 1'b0;
                    end
                end else begin
                    state_d     = ST_IDLE;
                    xfer_len_d  = len_q;
                    xfer_data_d = hold_q;
                    xfer_done_d = ~err_seen_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                len_d   = 8'd0;
            end
        endcase

        if (start_s) begin
            err_seen_d = |err_now_s;
        end else begin
            err_seen_d = err_seen_q | (|err_now_s);
        end

        // A clear only wipes history; an error found in the same cycle still lands
        if (clr_err) begin
            err_flags_d = err_now_s;
        end else begin
            err_flags_d = err_flags_q | err_now_s;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            len_q         <= 8'd0;
            hold_q        <= {DATA_W{1'b0}};
            err_seen_q    <= 1'b0;
            long_seen_q   <= 1'b0;
            nodrop_seen_q <= 1'b0;
            busy_q        <= 1'b0;
            err_flags_q   <= 7'b0;
            err_pulse_q   <= 1'b0;
            xfer_done_q   <= 1'b0;
            xfer_len_q    <= 8'd0;
            xfer_data_q   <= {DATA_W{1'b0}};
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            hold_q        <= hold_d;
            err_seen_q    <= err_seen_d;
            long_seen_q   <= long_seen_d;
            nodrop_seen_q <= nodrop_seen_d;
            busy_q        <= (state_d != ST_IDLE);
            err_flags_q   <= err_flags_d;
            err_pulse_q   <= |err_now_s;
            xfer_done_q   <= xfer_done_d;
            xfer_len_q    <= xfer_len_d;
            xfer_data_q   <= xfer_data_d;
        end
    end

    assign busy      = busy_q;
    assign err_flags = err_flags_q;
    assign err_pulse = err_pulse_q;
    assign xfer_done = xfer_done_q;
    assign xfer_len  = xfer_len_q;
    assign xfer_data = xfer_data_q;

`ifdef BUS_MON_STATS_EN
    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [CNT_W-1:0] xfer_count_q, xfer_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    // Statistics next-state, counting in step with the xfer_done / err_pulse registers
    always_comb begin
        if (xfer_done_d) begin
            xfer_count_d = cnt_sat_inc(xfer_count_q);
        end else begin
            xfer_count_d = xfer_count_q;
        end
        if (clr_err) begin
            err_count_d = (|err_now_s) ? {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b0}};
        end else if (|err_now_s) begin
            err_count_d = cnt_sat_inc(err_count_q);
        end else begin
            err_count_d = err_count_q;
        end
    end

    // Statistics registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xfer_count_q <= {CNT_W{1'b0}};
            err_count_q  <= {CNT_W{1'b0}};
        end else begin
            xfer_count_q <= xfer_count_d;
            err_count_q  <= err_count_d;
        end
    end

    assign xfer_count = xfer_count_q;
    assign err_count  = err_count_q;
`endif

endmodule

// File: doc/bus_protocol_monitor.md
BUS_PROTOCOL_MONITOR -- requirements
Module: bus_protocol_monitor

Interface
REQ-001 Parameter DATA_W, default 8, width of data and xfer_data.
REQ-002 Parameter MIN_VALID, default 2, minimum legal dValid-high cycles per transfer; must satisfy 1 <= MIN_VALID <= MAX_VALID.
REQ-003 Parameter MAX_VALID, default 4, maximum legal dValid-high cycles per transfer; must be <= 255.
REQ-004 Parameter CNT_W, default 16, width of the statistics counters.
REQ-005 Port clk  input  1  sole clock; all state updates on posedge clk.
REQ-006 Port reset  input  1  reset, asynchronous, active-high.
REQ-007 Port dValid  input  1  master data-valid, monitored only.
REQ-008 Port dAck  input  1  target acknowledge, monitored only.
REQ-009 Port data  input  DATA_W  bus data, monitored only.
REQ-010 Port clr_err  input  1  synchronous clear of err_flags and err_count.
REQ-011 Port busy  output  1  high while state is not IDLE.
REQ-012 Port err_flags  output  7  sticky error bits: [0] SHORT, [1] LONG, [2] EARLY_ACK, [3] NOACK, [4] NODROP, [5] DATA, [6] SPUR_ACK.
REQ-013 Port err_pulse  output  1  one-cycle pulse in every cycle in which at least one error is detected.
REQ-014 Port xfer_done  output  1  one-cycle pulse when a transfer completes without error.
REQ-015 Port xfer_len  output  8  dValid-high cycle count of the last completed transfer.
REQ-016 Port xfer_data  output  DATA_W  data captured at the start of the last completed transfer.

Function
REQ-017 FSM states: IDLE, ACTIVE, ACKED; len counts dValid-high cycles, set to 1 in the first cycle of a transfer.
REQ-018 IDLE with dValid=1 shall move to ACTIVE, set len=1, and capture data into the held-data register.
REQ-019 IDLE with dAck=1 and dValid=0 shall flag SPUR_ACK.
REQ-020 Any cycle with dValid=1 and dAck=1 where len < MIN_VALID, including the start cycle, shall flag EARLY_ACK and move to ACKED.
REQ-021 ACTIVE with dValid=1 shall increment len, saturating at 255, and flag DATA if data differs from the held value.
REQ-022 ACTIVE with dValid=1 and len = MAX_VALID+1 shall flag LONG exactly once per transfer.
REQ-023 ACTIVE with dValid=1 and dAck=1 shall move to ACKED; the data check of REQ-021 shall include this cycle.
REQ-024 ACTIVE with dValid=0 shall flag NOACK, also flag SHORT if len < MIN_VALID, and return to IDLE.
REQ-025 ACKED with dValid=0 shall return to IDLE, load xfer_len and xfer_data, and pulse xfer_done if no error was flagged during the transfer.
REQ-026 ACKED with dValid=1 shall flag NODROP once and remain in ACKED until dValid=0.
REQ-027 Errors shall be detected in the same cycle as the offending input; err_pulse and the err_flags update shall be registered, one cycle of latency.
REQ-028 clr_err in the same cycle as a new error: the new error shall win, and its bit shall be set after the clear.
REQ-029 dValid rising in the cycle immediately after ACKED->IDLE shall start a new transfer with no error.

Reset
REQ-030 reset shall asynchronously force state=IDLE, len=0, and busy, err_flags, err_pulse, xfer_done, xfer_len and xfer_data all to 0.
REQ-031 reset asserted mid-transfer shall abandon the transfer silently; no error shall be flagged and no xfer_done shall pulse.

Configuration
REQ-032 Macro BUS_MON_STATS_EN defined: the monitor adds outputs xfer_count [CNT_W] (incremented on each xfer_done) and err_count [CNT_W] (incremented on each err_pulse); both saturate at all-ones, reset to 0, and err_count is cleared by clr_err.
REQ-033 Macro BUS_MON_STATS_EN undefined: those ports and counters shall be absent, and all other behaviour shall be identical.

Verification
REQ-034 Defaults; dValid high 3 cycles, data=8'hA5 stable, dAck in cycle 3, dValid low in cycle 4 -> xfer_done=1, xfer_len=3, xfer_data=8'hA5, err_flags=0.
REQ-035 dValid high 1 cycle, no dAck -> err_flags=7'b0001001 (SHORT, NOACK), xfer_done stays 0.
REQ-036 dValid high 6 cycles, dAck in cycle 6 -> err_flags[1]=1 (LONG) set once, err_pulse exactly once for LONG.
REQ-037 dAck in cycle 2, dValid still high in cycle 3 -> err_flags[4]=1 (NODROP); data 8'h3C changing to 8'h3D in cycle 2 -> err_flags[5]=1 (DATA).
REQ-038 dAck high in IDLE -> err_flags[6]=1 (SPUR_ACK); clr_err pulse -> err_flags=0; reset asserted in cycle 2 of a transfer -> busy=0 immediately and no flags set.
REQ-039 With BUS_MON_STATS_EN: 3 legal transfers plus 1 SHORT transfer -> xfer_count=3, err_count=1.
